// File: rtl/regfile_dumper.sv
// regfile_dumper: debug read-out engine for the register file.
// On a start pulse it walks read port A through r0..r(NUM_REGS-1), captures each value
// and streams it out over a valid/ready handshake with index and last-flag sideband.
// hold (== busy) asks the core to stall so no register writes occur during the dump.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   dump request, sampled only in IDLE
//   selRa      out  regfile read port A select (owned by this block while busy)
//   ra         in   regfile read port A data (combinational read of selRa)
//   dumpValid  out  dumpData/dumpIdx/dumpLast valid
//   dumpReady  in   consumer ready; beat accepted when dumpValid && dumpReady at edge
//   dumpData   out  captured register value
//   dumpIdx    out  register number of dumpData
//   dumpLast   out  high with the final register's beat
//   busy       out  high whenever not IDLE
//   hold       out  core stall request, equal to busy
//   done       out  one-cycle pulse at end of dump
module regfile_dumper #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SEL_WIDTH  = 4,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [SEL_WIDTH-1:0]  selRa,
    input  logic [DATA_WIDTH-1:0] ra,
    output logic                  dumpValid,
    input  logic                  dumpReady,
    output logic [DATA_WIDTH-1:0] dumpData,
    output logic [SEL_WIDTH-1:0]  dumpIdx,
    output logic                  dumpLast,
    output logic                  busy,
    output logic                  hold,
    output logic                  done
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SEND,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [SEL_WIDTH-1:0]    didx_q, didx_d;
    logic                    last_q, last_d;
    logic                    valid_q, valid_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            didx_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        didx_d  = didx_q;
        last_d  = last_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETUP;
                    idx_d   = '0;
                end
            end
            S_SETUP: begin
                // selRa has been stable all cycle, so ra is settled at this edge
                data_d  = ra;
                didx_d  = idx_q;
                last_d  = (idx_q == LAST_IDX);
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (valid_q && dumpReady) begin
                    valid_d = 1'b0;
                    // The index stops at the last register so it never wraps
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + SEL_WIDTH'(1);
                        state_d = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        selRa     = '0;
        if (state_q == S_SETUP || state_q == S_SEND) begin
            selRa = idx_q;
        end
        busy      = (state_q != S_IDLE);
        hold      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        dumpValid = valid_q;
        dumpData  = data_q;
        dumpIdx   = didx_q;
        dumpLast  = last_q;
    end

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed testbench for regfile_dumper: a 16-register and a 4-register instance share
// a behavioural register file; beats, timing of done/busy and reset behaviour are checked.
module tb_regfile_dumper;

    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic        rdy;
    logic        use_b;
    logic [15:0] rf [16];

    logic        startA, startB;
    logic [3:0]  selA, selB;
    logic [15:0] raA, raB;
    logic        vA, vB, lastA, lastB, busyA, busyB, holdA, holdB, doneA, doneB;
    logic [15:0] dataA, dataB;
    logic [3:0]  idxA, idxB;

    logic        m_valid, m_last, m_busy, m_hold, m_done;
    logic [15:0] m_data;
    logic [3:0]  m_idx, m_sel;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign raA    = rf[selA];
    assign raB    = rf[selB];
    assign startA = st & ~use_b;
    assign startB = st & use_b;

    assign m_valid = use_b ? vB    : vA;
    assign m_last  = use_b ? lastB : lastA;
    assign m_busy  = use_b ? busyB : busyA;
    assign m_hold  = use_b ? holdB : holdA;
    assign m_done  = use_b ? doneB : doneA;
    assign m_data  = use_b ? dataB : dataA;
    assign m_idx   = use_b ? idxB  : idxA;
    assign m_sel   = use_b ? selB  : selA;

    regfile_dumper #(.DATA_WIDTH(16), .SEL_WIDTH(4), .NUM_REGS(16)) dutA (
        .clk(clk), .rst(rst), .start(startA), .selRa(selA), .ra(raA),
        .dumpValid(vA), .dumpReady(rdy), .dumpData(dataA), .dumpIdx(idxA),
        .dumpLast(lastA), .busy(busyA), .hold(holdA), .done(doneA)
    );

    regfile_dumper #(.DATA_WIDTH(16), .SEL_WIDTH(4), .NUM_REGS(4)) dutB (
        .clk(clk), .rst(rst), .start(startB), .selRa(selB), .ra(raB),
        .dumpValid(vB), .dumpReady(rdy), .dumpData(dataB), .dumpIdx(idxB),
        .dumpLast(lastB), .busy(busyB), .hold(holdB), .done(doneB)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag, input bit b);
        use_b = b;
        #0;
        chk({tag, "_sel"},   32'(m_sel),   0);
        chk({tag, "_valid"}, 32'(m_valid), 0);
        chk({tag, "_data"},  32'(m_data),  0);
        chk({tag, "_idx"},   32'(m_idx),   0);
        chk({tag, "_last"},  32'(m_last),  0);
        chk({tag, "_busy"},  32'(m_busy),  0);
        chk({tag, "_hold"},  32'(m_hold),  0);
        chk({tag, "_done"},  32'(m_done),  0);
    endtask

    // Run one full dump from IDLE. stall_idx/stall_n: hold ready low for stall_n cycles
    // on that beat; restart_idx: pulse start while that beat is presented; beef_idx:
    // overwrite that register once its beat is captured and stalled; start_in_done:
    // raise start during the DONE cycle and leave it high on return.
    task automatic dump(input bit useb, input int nregs, input int stall_idx, input int stall_n,
                        input int restart_idx, input int beef_idx, input bit start_in_done);
        int  e, beats, busy_cnt, done_cnt, done_e, stall_left;
        bit  fin, restarted;
        use_b = useb;
        rdy   = 1'b1;
        st    = 1'b1;
        tick();
        st = 1'b0;
        e = 0;
        chk("start_busy",  32'(m_busy),  1);
        chk("start_hold",  32'(m_hold),  1);
        chk("start_valid", 32'(m_valid), 0);
        busy_cnt   = 1;
        beats      = 0;
        done_cnt   = 0;
        done_e     = -1;
        stall_left = stall_n;
        fin        = 1'b0;
        restarted  = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            tick();
            e++;
            if (!m_busy) begin
                fin = 1'b1;
            end else begin
                st = 1'b0;
                busy_cnt++;
                if (m_valid) begin
                    chk("beat_idx",  32'(m_idx),  32'(beats));
                    chk("beat_data", 32'(m_data), 32'(16'h1000 + beats));
                    chk("beat_last", 32'(m_last), 32'(beats == nregs - 1));
                    chk("beat_sel",  32'(m_sel),  32'(beats));
                    if (int'(m_idx) == stall_idx && stall_left > 0) begin
                        rdy = 1'b0;
                        if (stall_left == stall_n && beef_idx == stall_idx)
                            rf[beef_idx] = 16'hBEEF;
                        stall_left--;
                    end else begin
                        rdy = 1'b1;
                        beats++;
                    end
                    if (int'(m_idx) == restart_idx && !restarted) begin
                        st = 1'b1;
                        restarted = 1'b1;
                    end
                end else begin
                    rdy = e[0];
                end
                if (m_done) begin
                    done_cnt++;
                    done_e = e;
                    if (start_in_done) st = 1'b1;
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        rdy = 1'b1;
        chk("beats",      32'(beats),    32'(nregs));
        chk("done_count", 32'(done_cnt), 1);
        chk("done_edge",  32'(done_e),   32'(2 * nregs + stall_n));
        chk("busy_cycles",32'(busy_cnt), 32'(2 * nregs + 1 + stall_n));
        chk("end_done",   32'(m_done),   0);
        chk("end_valid",  32'(m_valid),  0);
    endtask

    initial begin
        int found;
        rst   = 1'b1;
        st    = 1'b0;
        rdy   = 1'b0;
        use_b = 1'b0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
        tick();
        tick();
        chk_idle_zero("rst_A", 1'b0);
        chk_idle_zero("rst_B", 1'b1);
        rst = 1'b0;
        tick();
        chk_idle_zero("idle_A", 1'b0);

        // Basic dump, ready high throughout
        dump(1'b0, 16, -1, 0, -1, -1, 1'b0);
        // Backpressure on idx 3 for 5 cycles
        dump(1'b0, 16, 3, 5, -1, -1, 1'b0);
        // start during busy at idx 7, plus start raised in DONE cycle
        dump(1'b0, 16, -1, 0, 7, -1, 1'b1);
        // start left high from DONE: second full dump immediately
        dump(1'b0, 16, -1, 0, -1, -1, 1'b0);

        // Reset mid-dump while presenting idx 9
        use_b = 1'b0;
        rdy   = 1'b1;
        st    = 1'b1;
        tick();
        st = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            tick();
            if (m_valid && m_idx == 4'd9) found = 1;
        end
        chk("rst_reach_idx9", 32'(found), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_zero("midrst", 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_done", 32'(m_done), 0);
            chk("post_rst_busy", 32'(m_busy), 0);
        end
        dump(1'b0, 16, -1, 0, -1, -1, 1'b0);

        // Capture isolation: r2 rewritten while its beat is held
        dump(1'b0, 16, 2, 3, -1, 2, 1'b0);
        rf[2] = 16'h1002;

        // NUM_REGS=4 instance
        dump(1'b1, 4, -1, 0, -1, -1, 1'b0);
        dump(1'b1, 4, 3, 2, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
